// File: rtl/ace_snoop_initiator.sv
// ace_snoop_initiator
//   Initiator end of the ACE snoop channels. It issues one AC snoop request,
//   then collects the CR response and any CD line data from the cache under
//   test. Results are held in registers for an AXI-Lite status block. Only
//   one snoop is in flight at a time.
// Ports
//   ace_aclk, ace_areset          clock, synchronous active-high reset
//   i_start, i_acaddr/snoop/prot  launch request and its AC payload
//   o_acvalid, o_acaddr/snoop/prot, i_acready    AC channel
//   i_crvalid, i_crresp, o_crready               CR channel
//   i_cdvalid, i_cddata, i_cdlast, o_cdready     CD channel
//   o_busy, o_done                transaction status
//   o_crresp, o_line, o_beats, o_latency, o_timeout, o_proto_err  results
module ace_snoop_initiator #(
    parameter int C_ACE_DATA_WIDTH = 128,
    parameter int C_ACE_ADDR_WIDTH = 44,
    parameter int C_LINE_BYTES     = 64,
    parameter int C_TIMEOUT        = 1023
) (
    input  logic                          ace_aclk,
    input  logic                          ace_areset,
    input  logic                          i_start,
    input  logic [C_ACE_ADDR_WIDTH-1:0]   i_acaddr,
    input  logic [3:0]                    i_acsnoop,
    input  logic [2:0]                    i_acprot,
    output logic                          o_acvalid,
    output logic [C_ACE_ADDR_WIDTH-1:0]   o_acaddr,
    output logic [3:0]                    o_acsnoop,
    output logic [2:0]                    o_acprot,
    input  logic                          i_acready,
    input  logic                          i_crvalid,
    input  logic [4:0]                    i_crresp,
    output logic                          o_crready,
    input  logic                          i_cdvalid,
    input  logic [C_ACE_DATA_WIDTH-1:0]   i_cddata,
    input  logic                          i_cdlast,
    output logic                          o_cdready,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [4:0]                    o_crresp,
    output logic [C_LINE_BYTES*8-1:0]     o_line,
    output logic [7:0]                    o_beats,
    output logic [15:0]                   o_latency,
    output logic                          o_timeout,
    output logic                          o_proto_err
);

    localparam int LINE_W = C_LINE_BYTES * 8;
    localparam int BEATS  = LINE_W / C_ACE_DATA_WIDTH;
    localparam int TW     = $clog2(C_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AC   = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0]                  state_q, state_d;
    logic                        acvalid_q, acvalid_d;
    logic [C_ACE_ADDR_WIDTH-1:0] acaddr_q, acaddr_d;
    logic [3:0]                  acsnoop_q, acsnoop_d;
    logic [2:0]                  acprot_q, acprot_d;
    logic                        crready_q, crready_d;
    logic                        cdready_q, cdready_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [4:0]                  crresp_q, crresp_d;
    logic [LINE_W-1:0]           line_q, line_d;
    logic [7:0]                  beats_q, beats_d;
    logic [15:0]                 lat_q, lat_d;
    logic [TW-1:0]               tmo_q, tmo_d;
    logic                        timeout_q, timeout_d;
    logic                        perr_q, perr_d;
    logic                        cr_got_q, cr_got_d;
    logic                        cd_last_q, cd_last_d;

    logic cr_hs, cd_hs, cr_have, resp_dt, cd_last_have, beats_any, complete;

    // Readies are only ever high in RESP, so these are RESP-only events.
    assign cr_hs = i_crvalid & crready_q;
    assign cd_hs = i_cdvalid & cdready_q;

    // Completion looks at this cycle's handshakes as well as the captured
    // state, so a CR or final CD beat completes on the cycle it arrives.
    assign cr_have      = cr_got_q | cr_hs;
    assign resp_dt      = cr_got_q ? crresp_q[0] : i_crresp[0];
    assign cd_last_have = cd_last_q | (cd_hs & i_cdlast);
    assign beats_any    = (beats_q != 8'd0) | cd_hs;
    assign complete     = cr_have & (resp_dt ? cd_last_have
                                             : (!beats_any | cd_last_have));

    always_comb begin
        state_d   = state_q;
        acvalid_d = acvalid_q;
        acaddr_d  = acaddr_q;
        acsnoop_d = acsnoop_q;
        acprot_d  = acprot_q;
        crready_d = crready_q;
        cdready_d = cdready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        crresp_d  = crresp_q;
        line_d    = line_q;
        beats_d   = beats_q;
        lat_d     = lat_q;
        tmo_d     = tmo_q;
        timeout_d = timeout_q;
        perr_d    = perr_q;
        cr_got_d  = cr_got_q;
        cd_last_d = cd_last_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    acaddr_d  = i_acaddr;
                    acsnoop_d = i_acsnoop;
                    acprot_d  = i_acprot;
                    crresp_d  = 5'd0;
                    line_d    = '0;
                    beats_d   = 8'd0;
                    lat_d     = 16'd0;
                    timeout_d = 1'b0;
                    perr_d    = 1'b0;
                    cr_got_d  = 1'b0;
                    cd_last_d = 1'b0;
                    acvalid_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = S_AC;
                end
            end
            S_AC: begin
                if (i_acready) begin
                    acvalid_d = 1'b0;
                    crready_d = 1'b1;
                    cdready_d = 1'b1;
                    lat_d     = 16'd0;
                    tmo_d     = '0;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                lat_d = sat_inc16(lat_q);
                tmo_d = tmo_q + 1'b1;
                if (cr_hs) begin
                    crresp_d  = i_crresp;
                    cr_got_d  = 1'b1;
                    crready_d = 1'b0;
                end
                if (cd_hs) begin
                    beats_d = sat_inc8(beats_q);
                    for (int k = 0; k < BEATS; k++) begin
                        if (beats_q == 8'(k))
                            line_d[k*C_ACE_DATA_WIDTH +: C_ACE_DATA_WIDTH] = i_cddata;
                    end
                    // Overflow beats are dropped; a LAST that does not land on
                    // the final expected beat (or its absence there) is an error.
                    if (beats_q >= 8'(BEATS))
                        perr_d = 1'b1;
                    if (i_cdlast != (beats_q == 8'(BEATS - 1)))
                        perr_d = 1'b1;
                    if (i_cdlast) begin
                        cdready_d = 1'b0;
                        cd_last_d = 1'b1;
                    end
                end
                // Data beats against a response that promised no data.
                if (cr_have && !resp_dt && beats_any)
                    perr_d = 1'b1;
                if (complete) begin
                    crready_d = 1'b0;
                    cdready_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else if (tmo_q == TW'(C_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    crready_d = 1'b0;
                    cdready_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ace_aclk) begin
        if (ace_areset) begin
            state_q   <= S_IDLE;
            acvalid_q <= 1'b0;
            acaddr_q  <= '0;
            acsnoop_q <= 4'd0;
            acprot_q  <= 3'd0;
            crready_q <= 1'b0;
            cdready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            crresp_q  <= 5'd0;
            line_q    <= '0;
            beats_q   <= 8'd0;
            lat_q     <= 16'd0;
            tmo_q     <= '0;
            timeout_q <= 1'b0;
            perr_q    <= 1'b0;
            cr_got_q  <= 1'b0;
            cd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acvalid_q <= acvalid_d;
            acaddr_q  <= acaddr_d;
            acsnoop_q <= acsnoop_d;
            acprot_q  <= acprot_d;
            crready_q <= crready_d;
            cdready_q <= cdready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            crresp_q  <= crresp_d;
            line_q    <= line_d;
            beats_q   <= beats_d;
            lat_q     <= lat_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
            perr_q    <= perr_d;
            cr_got_q  <= cr_got_d;
            cd_last_q <= cd_last_d;
        end
    end

    assign o_acvalid   = acvalid_q;
    assign o_acaddr    = acaddr_q;
    assign o_acsnoop   = acsnoop_q;
    assign o_acprot    = acprot_q;
    assign o_crready   = crready_q;
    assign o_cdready   = cdready_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_crresp    = crresp_q;
    assign o_line      = line_q;
    assign o_beats     = beats_q;
    assign o_latency   = lat_q;
    assign o_timeout   = timeout_q;
    assign o_proto_err = perr_q;

endmodule

// File: tb/tb_ace_snoop_initiator.sv
module tb_ace_snoop_initiator;

    localparam int DW  = 128;
    localparam int AW  = 44;
    localparam int LB  = 64;
    localparam int TMO = 20;

    logic           ace_aclk = 1'b0;
    logic           ace_areset;
    logic           i_start;
    logic [AW-1:0]  i_acaddr;
    logic [3:0]     i_acsnoop;
    logic [2:0]     i_acprot;
    logic           o_acvalid;
    logic [AW-1:0]  o_acaddr;
    logic [3:0]     o_acsnoop;
    logic [2:0]     o_acprot;
    logic           i_acready;
    logic           i_crvalid;
    logic [4:0]     i_crresp;
    logic           o_crready;
    logic           i_cdvalid;
    logic [DW-1:0]  i_cddata;
    logic           i_cdlast;
    logic           o_cdready;
    logic           o_busy;
    logic           o_done;
    logic [4:0]     o_crresp;
    logic [LB*8-1:0] o_line;
    logic [7:0]     o_beats;
    logic [15:0]    o_latency;
    logic           o_timeout;
    logic           o_proto_err;

    ace_snoop_initiator #(
        .C_ACE_DATA_WIDTH(DW),
        .C_ACE_ADDR_WIDTH(AW),
        .C_LINE_BYTES(LB),
        .C_TIMEOUT(TMO)
    ) dut (
        .ace_aclk(ace_aclk), .ace_areset(ace_areset),
        .i_start(i_start), .i_acaddr(i_acaddr), .i_acsnoop(i_acsnoop), .i_acprot(i_acprot),
        .o_acvalid(o_acvalid), .o_acaddr(o_acaddr), .o_acsnoop(o_acsnoop), .o_acprot(o_acprot),
        .i_acready(i_acready),
        .i_crvalid(i_crvalid), .i_crresp(i_crresp), .o_crready(o_crready),
        .i_cdvalid(i_cdvalid), .i_cddata(i_cddata), .i_cdlast(i_cdlast), .o_cdready(o_cdready),
        .o_busy(o_busy), .o_done(o_done), .o_crresp(o_crresp), .o_line(o_line),
        .o_beats(o_beats), .o_latency(o_latency), .o_timeout(o_timeout),
        .o_proto_err(o_proto_err)
    );

    always #5 ace_aclk = ~ace_aclk;

    int n_chk = 0;
    int n_bad = 0;

    // Per-transaction observations filled in by run_snoop.
    int done_cnt, done_lat, acv_n, ac_bad, rdy_rel;
    bit finished;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge ace_aclk);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input int k);
        return 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 ^ {4{32'(k)}};
    endfunction

    // One snoop driven cycle by cycle. Delays are counted in clock edges
    // after the AC handshake edge at which the CR / first CD handshake lands.
    task automatic run_snoop(input logic [AW-1:0] addr, input logic [3:0] snp,
                             input logic [2:0] prot, input int ac_wait,
                             input bit cr_en, input int cr_dly, input logic [4:0] resp,
                             input int cd_dly, input int nbeats, input int last_at);
        int  e, ac_edge, rel, nb;
        bit  ac_hs, cr_hs, cd_hs, cr_done;
        e = 0; ac_edge = -1; nb = 0; cr_done = 0;
        done_cnt = 0; done_lat = -1; acv_n = 0; ac_bad = 0; rdy_rel = -1; finished = 0;
        i_acaddr = addr; i_acsnoop = snp; i_acprot = prot; i_crresp = resp;
        i_start = 1'b1;
        step;
        i_start = 1'b0;
        for (int it = 0; it < 200; it++) begin
            if (o_done) begin
                done_cnt++;
                done_lat = e - ac_edge;
            end
            if (done_cnt > 0 && !o_done && !o_busy) begin
                finished = 1;
                break;
            end
            if (o_crready && rdy_rel < 0 && ac_edge >= 0) rdy_rel = e - ac_edge;
            if (o_acvalid) begin
                if (o_acaddr !== addr || o_acsnoop !== snp || o_acprot !== prot) ac_bad++;
                i_acready = (acv_n >= ac_wait);
                acv_n++;
            end else begin
                i_acready = 1'b0;
            end
            ac_hs = o_acvalid && i_acready;
            rel = (ac_edge >= 0) ? (e + 1 - ac_edge) : 0;
            i_crvalid = (ac_edge >= 0) && cr_en && !cr_done && (rel >= cr_dly);
            cr_hs = i_crvalid && o_crready;
            i_cdvalid = (ac_edge >= 0) && (nb < nbeats) && (rel >= cd_dly);
            i_cddata = pat(nb);
            i_cdlast = (nb == last_at);
            cd_hs = i_cdvalid && o_cdready;
            step;
            e++;
            if (ac_hs) ac_edge = e;
            if (cr_hs) cr_done = 1;
            if (cd_hs) nb++;
        end
        i_acready = 1'b0; i_crvalid = 1'b0; i_cdvalid = 1'b0; i_cdlast = 1'b0;
        chk("finished", finished, 1'b1);
        chk("done_pulses", done_cnt, 1);
        chk("ac_stable", ac_bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end want end");
        $fatal(1, "watchdog");
    end

    initial begin
        ace_areset = 1'b1; i_start = 1'b0; i_acaddr = '0; i_acsnoop = 4'd0; i_acprot = 3'd0;
        i_acready = 1'b0; i_crvalid = 1'b0; i_crresp = 5'd0;
        i_cdvalid = 1'b0; i_cddata = '0; i_cdlast = 1'b0;
        step; step;
        chk("rst_acvalid", o_acvalid, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_ready", {o_crready, o_cdready}, 2'b00);
        chk("rst_results", {o_beats, o_latency, o_timeout, o_proto_err, o_crresp}, '0);
        chk("rst_line", o_line, '0);
        ace_areset = 1'b0;
        step;

        // 1: ReadShared, everything ready, full 4-beat line
        run_snoop(44'h123_4567_89C0, 4'b0001, 3'b010, 0, 1'b1, 1, 5'b00001, 1, 4, 3);
        chk("t1_beats", o_beats, 8'd4);
        chk("t1_line", o_line, {pat(3), pat(2), pat(1), pat(0)});
        chk("t1_perr", o_proto_err, 1'b0);
        chk("t1_tmo", o_timeout, 1'b0);
        chk("t1_crresp", o_crresp, 5'b00001);
        chk("t1_donelat", done_lat, 4);
        chk("t1_latency", o_latency, 16'd4);

        // 2: acready held low for 10 cycles
        run_snoop(44'hABC_DEF0_1240, 4'b0111, 3'b101, 10, 1'b1, 1, 5'b00000, 1, 0, 0);
        chk("t2_acvalid_cycles", acv_n, 11);
        chk("t2_resp_entry", rdy_rel, 0);
        chk("t2_latency", o_latency, 16'd1);
        chk("t2_beats", o_beats, 8'd0);

        // 3: no-data response after 5 cycles
        run_snoop(44'h000_0000_1000, 4'b0001, 3'b000, 0, 1'b1, 5, 5'b00000, 1, 0, 0);
        chk("t3_beats", o_beats, 8'd0);
        chk("t3_latency", o_latency, 16'd5);
        chk("t3_donelat", done_lat, 5);
        chk("t3_perr", o_proto_err, 1'b0);

        // 4: CD line first, CR with DataTransfer afterwards
        run_snoop(44'h000_0000_2040, 4'b0001, 3'b001, 0, 1'b1, 6, 5'b00001, 1, 4, 3);
        chk("t4_donelat", done_lat, 6);
        chk("t4_latency", o_latency, 16'd6);
        chk("t4_perr", o_proto_err, 1'b0);
        chk("t4_beats", o_beats, 8'd4);
        chk("t4_line", o_line, {pat(3), pat(2), pat(1), pat(0)});

        // 5a: crresp[0]=0 with a single LAST beat
        run_snoop(44'h000_0000_3000, 4'b0001, 3'b000, 0, 1'b1, 1, 5'b00000, 1, 1, 0);
        chk("t5a_perr", o_proto_err, 1'b1);
        chk("t5a_beats", o_beats, 8'd1);

        // 5b: LAST on beat 1
        run_snoop(44'h000_0000_3040, 4'b0001, 3'b000, 0, 1'b1, 1, 5'b00001, 1, 4, 1);
        chk("t5b_perr", o_proto_err, 1'b1);
        chk("t5b_beats", o_beats, 8'd2);
        chk("t5b_donelat", done_lat, 2);

        // 5c: crresp[0]=0 but a well-formed 4-beat line follows; drained to LAST
        run_snoop(44'h000_0000_3080, 4'b0001, 3'b000, 0, 1'b1, 1, 5'b00000, 1, 4, 3);
        chk("t5c_perr", o_proto_err, 1'b1);
        chk("t5c_beats", o_beats, 8'd4);
        chk("t5c_donelat", done_lat, 4);

        // 6: silent responder -> timeout
        run_snoop(44'h000_0000_4000, 4'b0001, 3'b000, 0, 1'b0, 1, 5'b00000, 1, 0, 0);
        chk("t6_timeout", o_timeout, 1'b1);
        chk("t6_donelat", done_lat, TMO);
        chk("t6_latency", o_latency, 16'(TMO));
        chk("t6_beats", o_beats, 8'd0);

        // 6b: reset while AC_ISSUE is waiting
        i_acaddr = 44'h000_0000_5000; i_acsnoop = 4'b0001; i_acprot = 3'b000;
        i_start = 1'b1;
        step;
        i_start = 1'b0;
        chk("t6b_acvalid_pre", o_acvalid, 1'b1);
        chk("t6b_busy_pre", o_busy, 1'b1);
        step;
        ace_areset = 1'b1;
        step;
        chk("t6b_acvalid", o_acvalid, 1'b0);
        chk("t6b_busy", o_busy, 1'b0);
        chk("t6b_addr", o_acaddr, '0);
        ace_areset = 1'b0;
        step;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
